// File: rtl/rf_arb_pkg.sv
// Shared defaults and requester IDs for the register-file writeback arbiter.
package rf_arb_pkg;
    localparam int RF_ARB_NREQ = 3;
    localparam int RF_ARB_AW   = 5;
    localparam int RF_ARB_DW   = 32;

    localparam int WB_SRC_PIPE = 0;
    localparam int WB_SRC_LSU  = 1;
    localparam int WB_SRC_MDU  = 2;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, looked up by decode.
module rf_scoreboard #(
    parameter int AW = 5
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic          flush,
    input  logic          clr0_en,
    input  logic [AW-1:0] clr0_addr,
    input  logic          clr1_en,
    input  logic [AW-1:0] clr1_addr,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          rs1_busy,
    output logic          rs2_busy
);
    localparam int NREG = 2 ** AW;

    logic [NREG-1:0] busy, busy_nxt;

    // Clears are applied before the issue set so a same-edge set of the same register wins.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (clr0_en) busy_nxt[clr0_addr] = 1'b0;
        if (clr1_en) busy_nxt[clr1_addr] = 1'b0;
        if (iss_valid && (iss_addr != '0)) busy_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    assign rs1_busy = (raddr1 != '0) && busy[raddr1];
    assign rs2_busy = (raddr2 != '0) && busy[raddr2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-path register-file writeback arbiter with registered output stage and RAW scoreboard.
// Optional RF_ARB_PERF_EN adds saturating conflict / dual-grant counters.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = RF_ARB_NREQ,
    parameter int AW   = RF_ARB_AW,
    parameter int DW   = RF_ARB_DW
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] wb_valid,
    output logic [NREQ-1:0] wb_ready,
    input  logic [NREQ*AW-1:0] wb_addr,
    input  logic [NREQ*DW-1:0] wb_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic            rf_rdt_req,
    output logic [AW-1:0]   rf_rdt_addr,
    output logic [DW-1:0]   rf_rdt_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic            flush,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic            rs1_busy,
    output logic            rs2_busy
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]     perf_conflict,
    output logic [31:0]     perf_dual
`endif
);
    localparam int PW = $clog2(NREQ);

    logic [AW-1:0] addr_a [NREQ];
    logic [DW-1:0] data_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g] = wb_addr[g*AW +: AW];
        assign data_a[g] = wb_data[g*DW +: DW];
    end

    logic [PW-1:0] rr_ptr, rr_ptr_nxt;
    logic [PW-1:0] prim_idx, sec_idx, cand, last_idx;
    logic [PW:0]   pos;
    logic          prim_vld, sec_vld, sec_seen, last_vld;

    // Walk the round-robin ring once from rr_ptr. The first valid entry after the
    // primary is the only secondary candidate; an address clash drops it for this cycle.
    always_comb begin
        prim_vld = wb_valid[WB_SRC_PIPE];
        prim_idx = '0;
        sec_vld  = 1'b0;
        sec_idx  = '0;
        sec_seen = 1'b0;
        pos      = '0;
        cand     = '0;
        for (int k = 0; k < NREQ-1; k++) begin
            pos = {1'b0, rr_ptr} + (PW+1)'(k);
            if (pos > (PW+1)'(NREQ-1)) pos = pos - (PW+1)'(NREQ-1);
            cand = pos[PW-1:0];
            if (wb_valid[cand]) begin
                if (!prim_vld) begin
                    prim_vld = 1'b1;
                    prim_idx = cand;
                end else if (!sec_seen) begin
                    sec_seen = 1'b1;
                    if (addr_a[cand] != addr_a[prim_idx]) begin
                        sec_vld = 1'b1;
                        sec_idx = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        wb_ready = '0;
        if (!reset) begin
            if (prim_vld) wb_ready[prim_idx] = 1'b1;
            if (sec_vld)  wb_ready[sec_idx]  = 1'b1;
        end
    end

    always_comb begin
        last_vld   = 1'b0;
        last_idx   = prim_idx;
        rr_ptr_nxt = rr_ptr;
        if (sec_vld) begin
            last_vld = 1'b1;
            last_idx = sec_idx;
        end else if (prim_vld && (prim_idx != '0)) begin
            last_vld = 1'b1;
        end
        if (last_vld)
            rr_ptr_nxt = (last_idx == PW'(NREQ-1)) ? PW'(1) : last_idx + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= PW'(1);
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            rf_rdt_req  <= 1'b0;
            rf_rdt_addr <= '0;
            rf_rdt_data <= '0;
        end else begin
            rr_ptr     <= rr_ptr_nxt;
            rf_we      <= prim_vld && (addr_a[prim_idx] != '0);
            rf_rdt_req <= sec_vld && (addr_a[sec_idx] != '0);
            if (prim_vld) begin
                rf_waddr <= addr_a[prim_idx];
                rf_wdata <= data_a[prim_idx];
            end
            if (sec_vld) begin
                rf_rdt_addr <= addr_a[sec_idx];
                rf_rdt_data <= data_a[sec_idx];
            end
        end
    end

    // Busy bits drop when the output stage drains, i.e. once the regfile holds the data.
    rf_scoreboard #(.AW(AW)) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .clr0_en   (rf_we),
        .clr0_addr (rf_waddr),
        .clr1_en   (rf_rdt_req),
        .clr1_addr (rf_rdt_addr),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

`ifdef RF_ARB_PERF_EN
    logic denied;
    assign denied = |(wb_valid & ~wb_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_conflict <= '0;
            perf_dual     <= '0;
        end else begin
            if (denied && (perf_conflict != '1))         perf_conflict <= perf_conflict + 32'd1;
            if (prim_vld && sec_vld && (perf_dual != '1)) perf_dual     <= perf_dual + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: queue-based reference model plus directed literal checks.
module tb_rf_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   wb_valid, wb_ready;
    logic [NREQ*AW-1:0] wb_addr;
    logic [NREQ*DW-1:0] wb_data;
    logic              rf_we, rf_rdt_req;
    logic [AW-1:0]     rf_waddr, rf_rdt_addr;
    logic [DW-1:0]     rf_wdata, rf_rdt_data;
    logic              iss_valid, flush;
    logic [AW-1:0]     iss_addr, raddr1, raddr2;
    logic              rs1_busy, rs2_busy;
`ifdef RF_ARB_PERF_EN
    logic [31:0]       perf_conflict, perf_dual;
`endif

    rf_wb_arbiter dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_rdt_req(rf_rdt_req), .rf_rdt_addr(rf_rdt_addr), .rf_rdt_data(rf_rdt_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .raddr1(raddr1), .raddr2(raddr2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
`ifdef RF_ARB_PERF_EN
        , .perf_conflict(perf_conflict), .perf_dual(perf_dual)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Grant rule: list requesters as [0, rr_ptr, rr_ptr+1, ...], keep the valid ones;
    // first is primary, second is secondary unless it targets the same register.
    function automatic void model_grant(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                                        input int ptr, output int p, output int s);
        int order[$];
        int cand[$];
        order.push_back(0);
        for (int k = 0; k < NREQ-1; k++) order.push_back(1 + (ptr - 1 + k) % (NREQ-1));
        foreach (order[j]) if (v[order[j]]) cand.push_back(order[j]);
        p = -1;
        s = -1;
        if (cand.size() > 0) p = cand[0];
        if (cand.size() > 1 && a[cand[1]*AW +: AW] != a[p*AW +: AW]) s = cand[1];
    endfunction

    int          m_ptr;
    logic        m_we, m_rdt;
    logic [AW-1:0] m_waddr, m_raddr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [31:0] m_busy;

    always @(posedge clk or posedge reset) begin
        int p, s, last;
        logic [31:0] nb;
        if (reset) begin
            m_ptr = 1; m_we = 0; m_rdt = 0; m_busy = '0;
            m_waddr = '0; m_raddr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            model_grant(wb_valid, wb_addr, m_ptr, p, s);
            nb = flush ? 32'd0 : m_busy;
            if (m_we)  nb[m_waddr] = 1'b0;
            if (m_rdt) nb[m_raddr] = 1'b0;
            if (iss_valid && iss_addr != 0) nb[iss_addr] = 1'b1;
            m_busy = nb;
            m_we  = (p >= 0) && (wb_addr[p*AW +: AW] != 0);
            m_rdt = (s >= 0) && (wb_addr[s*AW +: AW] != 0);
            if (p >= 0) begin m_waddr = wb_addr[p*AW +: AW]; m_wdata = wb_data[p*DW +: DW]; end
            if (s >= 0) begin m_raddr = wb_addr[s*AW +: AW]; m_rdata = wb_data[s*DW +: DW]; end
            last = (s > 0) ? s : ((p > 0) ? p : -1);
            if (last > 0) m_ptr = (last == NREQ-1) ? 1 : last + 1;
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        int p, s;
        logic [NREQ-1:0] er;
        if (cmp_en) begin
            model_grant(wb_valid, wb_addr, m_ptr, p, s);
            er = '0;
            if (!reset) begin
                if (p >= 0) er[p] = 1'b1;
                if (s >= 0) er[s] = 1'b1;
            end
            chk("m_wb_ready", wb_ready, er);
            chk("m_rf_we", rf_we, m_we);
            chk("m_rf_rdt_req", rf_rdt_req, m_rdt);
            if (m_we) begin
                chk("m_rf_waddr", rf_waddr, m_waddr);
                chk("m_rf_wdata", rf_wdata, m_wdata);
            end
            if (m_rdt) begin
                chk("m_rf_rdt_addr", rf_rdt_addr, m_raddr);
                chk("m_rf_rdt_data", rf_rdt_data, m_rdata);
            end
            chk("m_rs1_busy", rs1_busy, (raddr1 != 0) && m_busy[raddr1]);
            chk("m_rs2_busy", rs2_busy, (raddr2 != 0) && m_busy[raddr2]);
        end
    end

    logic [DW-1:0] tb_rf [32];
    always @(posedge clk) begin
        if (!reset) begin
            if (rf_we)      tb_rf[rf_waddr]    <= rf_wdata;
            if (rf_rdt_req) tb_rf[rf_rdt_addr] <= rf_rdt_data;
        end
    end

    logic [NREQ-1:0] gnt_q = '0;
    logic auto_drop = 1'b1;
    always @(negedge clk) gnt_q = wb_valid & wb_ready;

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) wb_valid = wb_valid & ~gnt_q;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_addr[i*AW +: AW] = a;
        wb_data[i*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int den1, den2;
        reset = 1'b1;
        wb_valid = '1; wb_addr = '0; wb_data = '0;
        iss_valid = 0; iss_addr = '0; flush = 0; raddr1 = '0; raddr2 = '0;
        set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2); set_req(2, 5'd3, 32'h3);
        @(posedge clk); #1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", wb_ready, 3'b000);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rdt_req", rf_rdt_req, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        wb_valid = '0;

        // single RR requester uses the primary path
        wb_valid = 3'b010; set_req(1, 5'd5, 32'h1234);
        @(negedge clk); chk("t1_ready", wb_ready, 3'b010);
        tick();
        @(negedge clk);
        chk("t1_we", rf_we, 1); chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'h1234); chk("t1_rdt_req", rf_rdt_req, 0);

        // pipe + mdu, distinct addresses -> dual grant
        wb_valid = 3'b101; set_req(0, 5'd3, 32'hAAAA_0003); set_req(2, 5'd7, 32'hBBBB_0007);
        @(negedge clk); chk("t2_ready", wb_ready, 3'b101);
        tick();
        @(negedge clk);
        chk("t2_we", rf_we, 1); chk("t2_waddr", rf_waddr, 3);
        chk("t2_rdt_req", rf_rdt_req, 1); chk("t2_rdt_addr", rf_rdt_addr, 7);
        chk("t2_rdt_data", rf_rdt_data, 32'hBBBB_0007);

        // same-address conflict: pipe wins, lsu follows, lsu data lands last
        wb_valid = 3'b011; set_req(0, 5'd9, 32'h0000_00A9); set_req(1, 5'd9, 32'h0000_00B9);
        @(negedge clk); chk("t3_ready0", wb_ready, 3'b001);
        tick();
        @(negedge clk); chk("t3_ready1", wb_ready, 3'b010); chk("t3_wdata0", rf_wdata, 32'hA9);
        tick();
        @(negedge clk); chk("t3_wdata1", rf_wdata, 32'hB9); chk("t3_rdt_req", rf_rdt_req, 0);
        tick();
        @(negedge clk); chk("t3_rf9", tb_rf[9], 32'hB9);

        // lsu and mdu held valid, same address then distinct: no one denied twice in a row
        auto_drop = 1'b0;
        set_req(1, 5'd6, 32'h6001); set_req(2, 5'd6, 32'h6002);
        wb_valid = 3'b110;
        den1 = 0; den2 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t4a_single", $countones(wb_ready), 1);
            den1 = (wb_valid[1] && !wb_ready[1]) ? den1 + 1 : 0;
            den2 = (wb_valid[2] && !wb_ready[2]) ? den2 + 1 : 0;
            chk("t4a_starve1", den1 <= 1, 1);
            chk("t4a_starve2", den2 <= 1, 1);
            tick();
        end
        set_req(2, 5'd7, 32'h7002);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t4b_dual", wb_ready, 3'b110);
            tick();
        end
        wb_valid = '0;
        auto_drop = 1'b1;

        // scoreboard: set on issue, clear one edge after grant
        iss_valid = 1; iss_addr = 5'd4; raddr1 = 5'd4;
        tick(); iss_valid = 0;
        @(negedge clk); chk("t5_busy_set", rs1_busy, 1);
        wb_valid = 3'b100; set_req(2, 5'd4, 32'h4444);
        tick();
        @(negedge clk); chk("t5_busy_N", rs1_busy, 1);
        tick();
        @(negedge clk); chk("t5_busy_N1", rs1_busy, 0);

        // flush clears, same-cycle issue still sets; register 0 never busy
        iss_valid = 1; iss_addr = 5'd8; raddr2 = 5'd8;
        tick();
        @(negedge clk); chk("t5_rs2_set", rs2_busy, 1);
        flush = 1; iss_addr = 5'd10; raddr1 = 5'd10;
        tick(); flush = 0; iss_valid = 0;
        @(negedge clk); chk("t5_flush_clr", rs2_busy, 0); chk("t5_flush_set", rs1_busy, 1);
        iss_valid = 1; iss_addr = 5'd0; raddr2 = 5'd0;
        tick(); iss_valid = 0;
        @(negedge clk); chk("t5_zero", rs2_busy, 0);

        // clear and set of r10 on the same edge: stays busy
        wb_valid = 3'b010; set_req(1, 5'd10, 32'h1010);
        tick();
        iss_valid = 1; iss_addr = 5'd10;
        tick(); iss_valid = 0;
        @(negedge clk); chk("t5_set_wins", rs1_busy, 1);

        // register 0 writes are accepted but never enable the regfile
        wb_valid = 3'b011; set_req(0, 5'd0, 32'hDEAD); set_req(1, 5'd6, 32'h0606);
        @(negedge clk); chk("t6_ready", wb_ready, 3'b011);
        tick();
        @(negedge clk); chk("t6_we0", rf_we, 0); chk("t6_rdt", rf_rdt_req, 1);
        chk("t6_rdt_addr", rf_rdt_addr, 6);
        wb_valid = 3'b100; set_req(2, 5'd0, 32'hBEEF);
        tick();
        @(negedge clk); chk("t6_we0b", rf_we, 0);

        // reset with a write sitting in the output stage
        wb_valid = 3'b010; set_req(1, 5'd12, 32'h0C0C);
        tick();
        @(negedge clk); chk("t7_we_pre", rf_we, 1);
        #2 reset = 1'b1;
        wb_valid = 3'b110; set_req(2, 5'd12, 32'h0C0D);
        #1;
        chk("t7_we_rst", rf_we, 0); chk("t7_ready_rst", wb_ready, 3'b000);
        chk("t7_busy_rst", rs1_busy, 0);
        @(negedge clk); #2 reset = 1'b0;
        #1; chk("t7_ptr_rst", wb_ready, 3'b010);
        tick();
        wb_valid = '0;
        repeat (3) tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
